// File: rtl/channel_llr_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// channel_llr_pingpong_buffer
//   Channel LLR buffer for the semi-parallel SC decoder. A frame of 2**N_LOG
//   LLRs arrives as beats of 2**M_LOG LLRs. Each LLR is stored at the
//   bit-reversed position of its natural index. Two banks are used as a
//   ping-pong pair, so the next frame can load while the decoder reads the
//   current one. Reads return 2**(P+1) consecutive positions per word, with
//   one registered cycle of latency.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_llr/in_last
//                  input beat stream; lane k of in_llr at [k*Q +: Q]
//   frame_err      1-cycle pulse when in_last disagrees with the beat count
//   frame_ready    read bank holds a complete, unclaimed frame
//   dec_start      decoder claims the ready bank
//   dec_busy       read bank is claimed
//   dec_done       decoder releases the claimed bank
//   rd_en/rd_addr  read request and word address
//   dout/dout_valid
//                  read word (LLR j at [j*Q +: Q]) one cycle after rd_en
// -----------------------------------------------------------------------------

// One stored LLR. Storage is write-only addressed by a decoded enable, so a
// cell is just a loadable register with no reset.
module channel_llr_cell #(
  parameter int Q = 6
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [Q-1:0] i_d,
  output logic [Q-1:0] o_q
);
  logic [Q-1:0] r_q;

  always_ff @(posedge clk)
    if (i_we) r_q <= i_d;

  assign o_q = r_q;
endmodule

// One lane of the read port: selects position addr*R + J from the bank
// currently being read and registers it. Holds its value when not enabled.
module channel_llr_rd_lane #(
  parameter int N_LOG = 3,
  parameter int P     = 1,
  parameter int Q     = 6,
  parameter int AW    = 1,
  parameter int J     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic [2**N_LOG-1:0][Q-1:0] i_word,
  input  logic [AW-1:0]              i_addr,
  output logic [Q-1:0]               o_q
);
  localparam int R = 2**(P+1);

  logic [N_LOG-1:0] w_idx;
  logic [Q-1:0]     r_q;

  // When N_LOG == P+1 the address is a tied-off dummy bit, so idx == J.
  assign w_idx = N_LOG'(int'(i_addr) * R + J);

  always_ff @(posedge clk or posedge rst)
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_word[w_idx];

  assign o_q = r_q;
endmodule

module channel_llr_pingpong_buffer #(
  parameter  int N_LOG = 3,
  parameter  int P     = 1,
  parameter  int Q     = 6,
  parameter  int M_LOG = 1,
  localparam int AW    = (N_LOG - P - 1 > 0) ? (N_LOG - P - 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(2**M_LOG)*Q-1:0]  in_llr,
  input  logic                     in_last,
  output logic                     frame_err,
  output logic                     frame_ready,
  input  logic                     dec_start,
  output logic                     dec_busy,
  input  logic                     dec_done,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic [(2**(P+1))*Q-1:0]  dout,
  output logic                     dout_valid
);
  localparam int N     = 2**N_LOG;
  localparam int M     = 2**M_LOG;
  localparam int R     = 2**(P+1);
  localparam int BEATS = 2**(N_LOG - M_LOG);
  localparam int CW    = (N_LOG > M_LOG) ? (N_LOG - M_LOG) : 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_st_e;

  function automatic int f_brev(int x);
    int r;
    r = 0;
    for (int b = 0; b < N_LOG; b++)
      if (((x >> b) & 1) != 0) r = r | (1 << (N_LOG - 1 - b));
    return r;
  endfunction

  bank_st_e                  r_st [0:1];
  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic [CW-1:0]             r_cnt;
  logic                      r_ferr;
  logic                      r_dv;

  bank_st_e                  w_wst;
  bank_st_e                  w_rst;
  logic                      w_acc;
  logic                      w_last;
  logic                      w_ready;
  logic                      w_busy;
  logic                      w_rd_fire;
  logic [1:0][N-1:0][Q-1:0]  w_mem;
  logic [N-1:0][Q-1:0]       w_rd_word;

  assign w_wst     = r_st[r_wr_bank];
  assign w_rst     = r_st[r_rd_bank];
  assign in_ready  = (w_wst == EMPTY) || (w_wst == FILLING);
  assign w_acc     = in_valid && in_ready;
  // With a single beat per frame r_cnt never leaves 0, so every beat is last.
  assign w_last    = (r_cnt == CW'(BEATS - 1));
  assign w_ready   = (w_rst == FULL);
  assign w_busy    = (w_rst == BUSY);
  assign w_rd_fire = rd_en && w_busy;

  assign frame_ready = w_ready;
  assign dec_busy    = w_busy;
  assign frame_err   = r_ferr;
  assign dout_valid  = r_dv;

  // Bank state machine. A write touches only an EMPTY/FILLING bank, a claim
  // only a FULL bank and a release only a BUSY bank, so the three updates
  // below can never target the same bank in one cycle and are all honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st[0]   <= EMPTY;
      r_st[1]   <= EMPTY;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_cnt     <= '0;
      r_ferr    <= 1'b0;
      r_dv      <= 1'b0;
    end else begin
      r_ferr <= w_acc && (in_last != w_last);
      r_dv   <= w_rd_fire;
      if (w_acc) begin
        r_st[r_wr_bank] <= w_last ? FULL : FILLING;
        if (w_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_cnt     <= '0;
        end else begin
          r_cnt     <= r_cnt + 1'b1;
        end
      end
      if (dec_start && w_ready)
        r_st[r_rd_bank] <= BUSY;
      if (dec_done && w_busy) begin
        r_st[r_rd_bank] <= EMPTY;
        r_rd_bank       <= ~r_rd_bank;
      end
    end
  end

  // Storage. Each position knows at compile time which beat and lane carry
  // its LLR (the natural index is the bit-reverse of the position), so the
  // write side needs no address arithmetic, only a beat-count compare.
  for (genvar bk = 0; bk < 2; bk++) begin : g_bank
    for (genvar p = 0; p < N; p++) begin : g_pos
      localparam int NAT  = f_brev(p);
      localparam int BEAT = NAT / M;
      localparam int LANE = NAT % M;
      logic w_we;
      assign w_we = w_acc && (r_wr_bank == 1'(bk)) && (r_cnt == CW'(BEAT));
      channel_llr_cell #(.Q(Q)) u_cell (
        .clk  (clk),
        .i_we (w_we),
        .i_d  (in_llr[LANE*Q +: Q]),
        .o_q  (w_mem[bk][p])
      );
    end
  end

  // Read port. A read in the same cycle as dec_done still sees the
  // pre-release rd_bank, since the pointer only moves at the edge.
  assign w_rd_word = w_mem[r_rd_bank];

  for (genvar j = 0; j < R; j++) begin : g_rd
    channel_llr_rd_lane #(
      .N_LOG (N_LOG),
      .P     (P),
      .Q     (Q),
      .AW    (AW),
      .J     (j)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_rd_fire),
      .i_word (w_rd_word),
      .i_addr (rd_addr),
      .o_q    (dout[j*Q +: Q])
    );
  end
endmodule
